// File: rtl/onehot_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : onehot_scan_decoder
//  Purpose  : Registered binary-to-one-hot decoder with enable and a scan
//             mode that walks the active line through every position, holding
//             each one for DWELL cycles. Every output comes from a flop, so it
//             can drive pads or downstream logic directly.
//  Ports    :
//    clk      in   1      rising-edge clock
//    rst      in   1      synchronous active-high reset
//    in       in   IN_W   select index (direct) / start index (scan entry)
//    enable   in   1      1 = outputs active, 0 = all outputs low
//    mode     in   1      0 = direct decode, 1 = scan
//    scan_dir in   1      0 = ascending, 1 = descending
//    out      out  OUT_W  registered one-hot select, zero when disabled
//    idx      out  IN_W   registered index currently decoded onto out
//    wrap     out  1      one-cycle pulse when a scan step wraps around
//  Revision : 1.0 - initial release
// ============================================================================
module onehot_scan_decoder #(
  parameter int IN_W  = 3,
  parameter int DWELL = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IN_W-1:0]    in,
  input  logic               enable,
  input  logic               mode,
  input  logic               scan_dir,
  output logic [2**IN_W-1:0] out,
  output logic [IN_W-1:0]    idx,
  output logic               wrap
);

  localparam int OUT_W = 2**IN_W;
  // A single-cycle dwell still gets a 1-bit counter; it simply stays at 0.
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IN_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wrap_q, wrap_d;
  logic [OUT_W-1:0]   out_q, out_d;

  logic               active_d;   // next cycle drives a line at all
  logic [OUT_W-1:0]   dec_d;      // one-hot decode of idx_d
  logic [IN_W-1:0]    step_idx;   // neighbour index in the scan direction
  logic               step_wraps; // neighbour lies across the 0 / OUT_W-1 seam

  // --------------------------------------------------------------------------
  // Next-state decision: purely from the sampled enable/mode pair.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = ST_OFF;
    if (enable) begin
      state_d = mode ? ST_SCAN : ST_DIRECT;
    end
  end

  // Index arithmetic wraps naturally because OUT_W is exactly 2**IN_W.
  always_comb begin
    step_idx   = scan_dir ? (idx_q - IN_W'(1)) : (idx_q + IN_W'(1));
    step_wraps = scan_dir ? (idx_q == '0) : (idx_q == '1);
  end

  // --------------------------------------------------------------------------
  // Datapath next values.
  // --------------------------------------------------------------------------
  always_comb begin
    idx_d    = idx_q;      // OFF holds the last index
    cnt_d    = '0;
    wrap_d   = 1'b0;
    active_d = 1'b0;
    unique case (state_d)
      ST_DIRECT: begin
        idx_d    = in;
        active_d = 1'b1;
      end
      ST_SCAN: begin
        active_d = 1'b1;
        if (state_q != ST_SCAN) begin
          // Entry: load the start index; it then dwells like any other.
          idx_d = in;
        end else if (cnt_q == CNT_LAST) begin
          // Step cycle: the only point where scan_dir is consulted.
          idx_d  = step_idx;
          wrap_d = step_wraps;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        active_d = 1'b0;
      end
    endcase
  end

  // One comparator per output line keeps out == 1 << idx by construction.
  for (genvar i = 0; i < OUT_W; i++) begin : g_decode
    assign dec_d[i] = (idx_d == IN_W'(i));
  end

  always_comb begin
    out_d = active_d ? dec_d : '0;
  end

  // --------------------------------------------------------------------------
  // State and output registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      idx_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      out_q   <= out_d;
    end
  end

  assign out  = out_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_onehot_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_onehot_scan_decoder
//  Purpose  : Scoreboard bench for onehot_scan_decoder. Three instances share
//             one stimulus stream: (IN_W=3,DWELL=4), (IN_W=3,DWELL=1) and
//             (IN_W=4,DWELL=2). A behavioural model pushes expected outputs
//             per instance; a monitor pops and compares every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_onehot_scan_decoder;

  typedef struct packed {
    logic [15:0] out;
    logic [3:0]  idx;
    logic        wrap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_s = '0;
  logic [2:0] in3;
  logic       enable = 1'b0;
  logic       mode = 1'b0;
  logic       scan_dir = 1'b0;

  logic [7:0]  out0, out1;
  logic [15:0] out2;
  logic [2:0]  idx0, idx1;
  logic [3:0]  idx2;
  logic        wrap0, wrap1, wrap2;

  assign in3 = in_s[2:0];

  always #5 clk = ~clk;

  onehot_scan_decoder #(.IN_W(3), .DWELL(4)) u_d0 (
    .clk(clk), .rst(rst), .in(in3), .enable(enable), .mode(mode),
    .scan_dir(scan_dir), .out(out0), .idx(idx0), .wrap(wrap0));

  onehot_scan_decoder #(.IN_W(3), .DWELL(1)) u_d1 (
    .clk(clk), .rst(rst), .in(in3), .enable(enable), .mode(mode),
    .scan_dir(scan_dir), .out(out1), .idx(idx1), .wrap(wrap1));

  onehot_scan_decoder #(.IN_W(4), .DWELL(2)) u_d2 (
    .clk(clk), .rst(rst), .in(in_s), .enable(enable), .mode(mode),
    .scan_dir(scan_dir), .out(out2), .idx(idx2), .wrap(wrap2));

  // Scoreboard queues, one per instance.
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference model state (higher level: "am I scanning, where, how many
  // cycles are left at this position").
  int iw_tab[3] = '{3, 3, 4};
  int dw_tab[3] = '{4, 1, 2};
  int m_idx[3]  = '{0, 0, 0};
  int m_left[3] = '{0, 0, 0};
  bit m_scan[3] = '{0, 0, 0};

  task automatic model_push(input bit r, input bit en, input bit md,
                            input bit dir, input int in_v);
    for (int k = 0; k < 3; k++) begin
      int   n;
      int   v;
      bit   on;
      bit   w;
      exp_t e;
      n  = 1 << iw_tab[k];
      v  = in_v % n;
      on = 1'b0;
      w  = 1'b0;
      if (r) begin
        m_idx[k]  = 0;
        m_scan[k] = 1'b0;
      end else if (!en) begin
        m_scan[k] = 1'b0;
      end else if (!md) begin
        m_idx[k]  = v;
        m_scan[k] = 1'b0;
        on        = 1'b1;
      end else if (!m_scan[k]) begin
        m_idx[k]  = v;
        m_left[k] = dw_tab[k];
        m_scan[k] = 1'b1;
        on        = 1'b1;
      end else begin
        on        = 1'b1;
        m_left[k] = m_left[k] - 1;
        if (m_left[k] == 0) begin
          w         = dir ? (m_idx[k] == 0) : (m_idx[k] == n - 1);
          m_idx[k]  = (m_idx[k] + (dir ? n - 1 : 1)) % n;
          m_left[k] = dw_tab[k];
        end
      end
      e.out  = on ? 16'(32'd1 << m_idx[k]) : 16'h0;
      e.idx  = 4'(m_idx[k]);
      e.wrap = w;
      case (k)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endtask

  // Drive one cycle of inputs, record expectations, advance past the edge.
  task automatic cyc(input bit r, input bit en, input bit md, input bit dir,
                     input int in_v);
    rst      = r;
    enable   = en;
    mode     = md;
    scan_dir = dir;
    in_s     = 4'(in_v);
    model_push(r, en, md, dir, in_v);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input int k, input exp_t e, input logic [15:0] a_out,
                       input logic [3:0] a_idx, input logic a_wrap);
    checks++;
    if (a_out !== e.out || a_idx !== e.idx || a_wrap !== e.wrap) begin
      errors++;
      $display("FAIL inst%0d cycle %0d: got out=%h idx=%0d wrap=%b, expected out=%h idx=%0d wrap=%b",
               k, cycle, a_out, a_idx, a_wrap, e.out, e.idx, e.wrap);
    end
  endtask

  // Monitor: every cycle presents a registered result; compare on negedge.
  always @(negedge clk) begin
    exp_t e;
    cycle++;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check(0, e, {8'h00, out0}, {1'b0, idx0}, wrap0);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check(1, e, {8'h00, out1}, {1'b0, idx1}, wrap1);
    end
    if (q2.size() > 0) begin
      e = q2.pop_front();
      check(2, e, out2, idx2, wrap2);
    end
  end

  initial begin
    bit r_b, en_b, md_b, dir_b;

    // Reset held two cycles with enable/mode asserted.
    cyc(1, 1, 1, 0, 5);
    cyc(1, 1, 1, 0, 5);
    // Release straight into direct decode of 3.
    cyc(0, 1, 0, 0, 3);

    // Disabled sweep, then enabled direct sweep.
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, i);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, i);

    // Ascending scan from 6.
    cyc(0, 0, 1, 0, 6);
    for (int i = 0; i < 14; i++) cyc(0, 1, 1, 0, (i == 0) ? 6 : i);

    // Descending scan from 1.
    cyc(0, 0, 1, 1, 1);
    for (int i = 0; i < 10; i++) cyc(0, 1, 1, 1, 1);

    // Direction flip mid-dwell.
    cyc(0, 0, 1, 0, 2);
    cyc(0, 1, 1, 0, 2);
    cyc(0, 1, 1, 0, 2);
    for (int i = 0; i < 8; i++) cyc(0, 1, 1, 1, 7);

    // Reset mid-scan, then resume scanning.
    cyc(0, 0, 1, 0, 4);
    cyc(0, 1, 1, 0, 4);
    cyc(0, 1, 1, 0, 4);
    cyc(0, 1, 1, 0, 4);
    cyc(1, 1, 1, 0, 4);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 5);

    // One-cycle enable drop restarts from in.
    cyc(0, 0, 1, 0, 5);
    for (int i = 0; i < 6; i++) cyc(0, 1, 1, 0, 1);

    // Direct -> scan with the same index.
    cyc(0, 1, 0, 0, 15);
    for (int i = 0; i < 6; i++) cyc(0, 1, 1, 0, 15);

    // Scan -> direct.
    cyc(0, 1, 0, 0, 9);

    // Randomised traffic.
    dir_b = 1'b0;
    for (int i = 0; i < 600; i++) begin
      r_b  = ($urandom_range(0, 40) == 0);
      en_b = ($urandom_range(0, 15) != 0);
      md_b = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) dir_b = ~dir_b;
      cyc(r_b, en_b, md_b, dir_b, int'($urandom_range(0, 15)));
    end

    // Drain: every expectation must have been consumed.
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0",
               q0.size() + q1.size() + q2.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/onehot_scan_decoder.md
# onehot_scan_decoder

Parametrised, registered binary-to-one-hot decoder with enable. It succeeds the combinational 3-to-8 decoder. In addition to direct decode, it has a scan mode that walks the active output line through all positions with a programmable dwell time. It drives row/digit-select lines in lab display and multiplexing designs, and it registers every output so it can feed pads or downstream logic directly.

## Interface
- IN_W, 3, select width; OUT_W = 2**IN_W output lines (derived localparam, not overridable); IN_W ≥ 1
- DWELL, 4, cycles each line stays active in scan mode; DWELL ≥ 1
- clk  input  1  rising-edge clock; one clock domain
- rst  input  1  reset, synchronous, active-high
- in  input  IN_W  select index (direct mode) / start index (scan entry)
- enable  input  1  1 = outputs active; 0 = all outputs low
- mode  input  1  0 = direct decode, 1 = scan
- scan_dir  input  1  0 = ascending index, 1 = descending
- out  output  OUT_W  one-hot select, registered; all-zero when disabled
- idx  output  IN_W  index currently decoded onto out, registered
- wrap  output  1  one-cycle pulse when a scan step wraps around

## Operation
- FSM, three states: OFF, DIRECT, SCAN. Next state is decided each cycle from the sampled inputs:
  - enable=0 → OFF
  - enable=1, mode=0 → DIRECT
  - enable=1, mode=1 → SCAN
- Dwell counter cnt is clog2(DWELL) bits wide (minimum 1 bit). It runs 0..DWELL-1.
- OFF:
  - out <= 0; wrap <= 0; cnt <= 0
  - idx holds its last value
- DIRECT:
  - out <= 1 << in; idx <= in; wrap <= 0; cnt <= 0
- SCAN entry (current state ≠ SCAN, next = SCAN):
  - idx <= in; out <= 1 << in; cnt <= 0; wrap <= 0
- SCAN steady state (current = SCAN, next = SCAN):
  - If cnt < DWELL-1: cnt <= cnt+1; idx, out hold; wrap <= 0.
  - If cnt == DWELL-1: cnt <= 0. idx steps to idx+1 (scan_dir=0) or idx-1 (scan_dir=1), modulo OUT_W. out <= 1 << new idx.
  - wrap <= 1 only when the step goes OUT_W-1 → 0 (ascending) or 0 → OUT_W-1 (descending); otherwise wrap <= 0.
- in is ignored in SCAN after the entry cycle.
- scan_dir is sampled only on the step cycle. Changing it mid-dwell does not reset cnt.
- Invariant: whenever out ≠ 0, out == 1 << idx, and exactly one bit is set.
- Reset (rst=1 at a clock edge) overrides everything, including a scan in progress:
  - state OFF, out=0, idx=0, cnt=0, wrap=0
- The first cycle after rst deasserts behaves as an entry from OFF.

## Timing
- All outputs are registered. Latency from in/enable/mode to out/idx is 1 cycle.
- There is no combinational input-to-output path.
- Scan cadence: each index is held exactly DWELL cycles, including the start index loaded at entry.
  - DWELL=1: idx changes every cycle.
- wrap is asserted in the same cycle in which out/idx first show the wrapped index. It lasts exactly 1 cycle.
- SCAN → DIRECT: the next cycle shows 1 << in. Scan position is lost; re-entering SCAN restarts from in.
- SCAN → OFF → SCAN: restarts from in with cnt=0. There is no resume.
- DIRECT → SCAN with the same in: out unchanged on entry, then the first step occurs DWELL cycles later.
- Simultaneous rst and any input change: rst wins.

## Test plan
- Reset: hold rst 2 cycles with enable=1, mode=1 → out=0x00, idx=0, wrap=0. After release with in=3, mode=0, next cycle → out=0x08.
- Direct sweep, IN_W=3: enable=0 with in=0..7 → out=0x00 each cycle. enable=1 with in=0..7 → out=0x01,0x02,…,0x80, each 1 cycle after the input.
- Ascending scan, DWELL=4: enable=1, mode=1, scan_dir=0, in=6.
  - out=0x40 for 4 cycles, then 0x80 for 4 cycles.
  - Then 0x01 with idx=0 and wrap=1 for exactly that one cycle.
  - Then 0x01 for 3 more cycles with wrap=0.
- Descending scan, DWELL=1, in=1: out=0x02, 0x01, 0x80 (wrap=1), 0x40, …
- Mid-scan disturbances:
  - Flip scan_dir at cnt=1 → next step goes the opposite direction, on schedule.
  - Assert rst at cnt=2 → next cycle out=0, idx=0.
  - Drop enable for 1 cycle → out=0x00, then restart from in.
- Width generalisation, IN_W=4, DWELL=2: direct in=15 → out=0x8000. Ascending scan from 15 → 0x8000 for 2 cycles, then 0x0001 with wrap=1.
